digital_pi_lf_q: RTL
====================

// Module: digital_pi_lf_q
// PURPOSE
//  Second-generation Rx CDR digital loop filter: proportional + integral (2nd-order) path driving a
//  phase-interpolator code with quadrant bits. Shift-based gains, a parametrised Nl-stage input latency
//  line, wrap-around phase accumulation, a saturating frequency integrator and a freeze (holdover) mode.
//  Sits between the mmpd error output and the PI control input.
// PARAMETERS
//  ADC_BIT   8   width of signed phase-error input
//  PI_BIT    6   PI resolution per quadrant; out width = PI_BIT+2
//  FRAC_BIT  8   fractional bits of phase accumulator (PH_W = PI_BIT+2+FRAC_BIT)
//  FREQ_BIT  16  width of signed frequency integrator (LSB = phase-acc LSB)
//  KP_SHIFT  2   proportional gain = 2^(FRAC_BIT-KP_SHIFT) phase LSB per error LSB
//  KI_SHIFT  6   integral gain = 2^(FRAC_BIT-KI_SHIFT) freq LSB per error LSB; KI_SHIFT >= KP_SHIFT
//  NL        2   loop latency stages on (in, in_valid); 0 = no delay
//  OFFSET    0   [PI_BIT+1:0] initial/disabled PI code
// PORTS
//  clk        in   1             triggering clock
//  rst        in   1             async active-high reset
//  filter_en  in   1             0: hold OFFSET, clear state; 1: run loop
//  freeze     in   1             1: holdover, errors ignored, freq held
//  in         in   ADC_BIT       signed phase error from mmpd
//  in_valid   in   1             in qualifies this cycle
//  out        out  PI_BIT+2      PI code = phase_acc[PH_W-1:FRAC_BIT]
//  freq_out   out  FREQ_BIT      signed frequency integrator state (monitor)
//  sat_flag   out  1             sticky: freq integrator clamped since last clear
// BEHAVIOUR
//  - Reset (rst=1, async) or filter_en=0 (sync, next edge): phase_acc=OFFSET<<FRAC_BIT, freq_acc=0,
//    delay line zeroed (valids=0), sat_flag=0 -> out=OFFSET, freq_out=0. rst dominates.
//  - Delay line: (in,in_valid) shifted through NL registers; d_e/d_v = stage-NL output. Only when
//    filter_en=1; rst mid-operation discards in-flight samples.
//  - e = freeze ? 0 : d_e (sign-extended). p = (e<<<FRAC_BIT)>>>KP_SHIFT; i = (e<<<FRAC_BIT)>>>KI_SHIFT
//    (arithmetic, computed at width >= max(PH_W,FREQ_BIT)+1).
//  - Update on edge where filter_en=1 and d_v=1:
//      phase_acc <= phase_acc + p + sext(freq_acc)  (pre-update freq; mod 2^PH_W, wraps freely)
//      freq_acc  <= sat(freq_acc + i), clamp to [-(2^(FREQ_BIT-1)-1), 2^(FREQ_BIT-1)-1]
//  - freeze=1 with d_v=1: phase advances by freq_acc only; freq_acc unchanged; sat_flag unchanged.
//  - d_v=0: all state holds. freeze toggling does not flush delay line.
//  - Latency: sample with in_valid at edge k updates out at edge k+NL+1 (out registered-derived).
//  - Wrap: out rolls 2^(PI_BIT+2)-1 -> 0 upward and 0 -> max downward; no glitch, no flag.
//  - Saturation: any clamp sets sat_flag=1; cleared only by rst or filter_en=0.
//  - Negative e: same equations; truncation of >>> rounds toward -inf.
// TESTING
//  1. rst pulse, OFFSET=8'd37, filter_en=0 -> out=37, freq_out=0, sat_flag=0; stays 37 with in_valid toggling.
//  2. filter_en=1, single in=+16 valid, then in=0 valid each cycle -> out=37+4 at edge NL+1,
//     freq_out=64; phase then +64/sample, out +1 every 4 samples.
//  3. Latency sweep NL=0,2,5 -> first out change exactly NL+1 edges after valid sample.
//  4. Wrap: OFFSET=255, in=+16 once -> out 255 -> 3; in=-16 from 0 -> out 0 -> 252.
//  5. in=+127 every cycle -> freq_out clamps at 32767 after 65 samples, sat_flag=1 sticky
//     until filter_en=0; in=-127 from clamp decreases freq, no wrap.
//  6. freeze=1 with freq_out=64, in=+100 valid -> freq held 64, phase +64/sample; rst mid-stream -> out=OFFSET.

Source files
------------

// File: rtl/digital_pi_lf_q.sv
// Rx CDR digital loop filter: proportional + integral path feeding a
// phase-interpolator code (PI_BIT bits per quadrant plus two quadrant bits).
// The input error passes through an NL-stage latency line. The phase
// accumulator wraps freely. The frequency integrator saturates symmetrically,
// and freeze holds it while the phase keeps slewing at the learned rate.
module digital_pi_lf_q #(
  parameter int unsigned ADC_BIT  = 8,
  parameter int unsigned PI_BIT   = 6,
  parameter int unsigned FRAC_BIT = 8,
  parameter int unsigned FREQ_BIT = 16,
  parameter int unsigned KP_SHIFT = 2,
  parameter int unsigned KI_SHIFT = 6,
  parameter int unsigned NL       = 2,
  parameter logic [PI_BIT+1:0] OFFSET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_filter_en,
  input  logic                i_freeze,
  input  logic [ADC_BIT-1:0]  i_in,
  input  logic                i_in_valid,
  output logic [PI_BIT+1:0]   o_out,
  output logic [FREQ_BIT-1:0] o_freq_out,
  output logic                o_sat_flag
);

  localparam int unsigned PH_W = PI_BIT + 2 + FRAC_BIT;
  localparam int unsigned MW1  = (PH_W > FREQ_BIT) ? PH_W : FREQ_BIT;
  localparam int unsigned MW2  = (MW1 > ADC_BIT + FRAC_BIT) ? MW1 : ADC_BIT + FRAC_BIT;
  // One guard bit above every operand so sums and clamp compares cannot overflow
  localparam int unsigned CW   = MW2 + 1;

  localparam logic [PH_W-1:0] OFFSET_PH = PH_W'(OFFSET) << FRAC_BIT;

  // Symmetric clamp limits: +/-(2^(FREQ_BIT-1)-1)
  localparam logic signed [CW-1:0] FREQ_MAX = {{(CW-FREQ_BIT+1){1'b0}}, {(FREQ_BIT-1){1'b1}}};
  localparam logic signed [CW-1:0] FREQ_MIN = -FREQ_MAX;

  logic [PH_W-1:0]     r_phase_acc;
  logic [FREQ_BIT-1:0] r_freq_acc;
  logic                r_sat;

  logic [ADC_BIT-1:0]  w_d_e;
  logic                w_d_v;

  // ---------------------------------------------------------------------------
  // Input latency line
  // ---------------------------------------------------------------------------
  if (NL == 0) begin : g_no_dly
    assign w_d_e = i_in;
    assign w_d_v = i_in_valid;
  end else begin : g_dly
    logic [ADC_BIT-1:0] r_dly_e [NL];
    logic [NL-1:0]      r_dly_v;

    // Shift (error, valid) pairs; disabling the filter flushes in-flight samples
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < NL; s++) r_dly_e[s] <= '0;
        r_dly_v <= '0;
      end else if (!i_filter_en) begin
        for (int s = 0; s < NL; s++) r_dly_e[s] <= '0;
        r_dly_v <= '0;
      end else begin
        r_dly_e[0] <= i_in;
        r_dly_v[0] <= i_in_valid;
        for (int s = 1; s < NL; s++) begin
          r_dly_e[s] <= r_dly_e[s-1];
          r_dly_v[s] <= r_dly_v[s-1];
        end
      end
    end

    assign w_d_e = r_dly_e[NL-1];
    assign w_d_v = r_dly_v[NL-1];
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] w_e_ext;
  logic signed [CW-1:0] w_e_sh;
  logic signed [CW-1:0] w_p;
  logic signed [CW-1:0] w_i;
  logic signed [CW-1:0] w_freq_ext;
  logic signed [CW-1:0] w_freq_sum;
  logic        [CW-1:0] w_ph_full;
  logic [FREQ_BIT-1:0]  w_freq_next;
  logic                 w_clamp;
  logic                 w_unused;

  // Gains as arithmetic shifts; freeze zeroes the error so only the frequency term remains
  always_comb begin
    w_e_ext    = i_freeze ? '0 : {{(CW-ADC_BIT){w_d_e[ADC_BIT-1]}}, w_d_e};
    w_e_sh     = w_e_ext <<< FRAC_BIT;
    w_p        = w_e_sh >>> KP_SHIFT;
    w_i        = w_e_sh >>> KI_SHIFT;
    w_freq_ext = {{(CW-FREQ_BIT){r_freq_acc[FREQ_BIT-1]}}, r_freq_acc};
    // Phase uses the pre-update frequency; the result is taken mod 2^PH_W
    w_ph_full  = CW'(r_phase_acc) + w_p + w_freq_ext;
    w_freq_sum = w_freq_ext + w_i;
  end

  // Saturate the frequency integrator and flag any clamp
  always_comb begin
    w_freq_next = w_freq_sum[FREQ_BIT-1:0];
    w_clamp     = 1'b0;
    if (w_freq_sum > FREQ_MAX) begin
      w_freq_next = FREQ_MAX[FREQ_BIT-1:0];
      w_clamp     = 1'b1;
    end else if (w_freq_sum < FREQ_MIN) begin
      w_freq_next = FREQ_MIN[FREQ_BIT-1:0];
      w_clamp     = 1'b1;
    end
  end

  // Bits above PH_W are the discarded wrap carry
  assign w_unused = ^w_ph_full[CW-1:PH_W];

  // ---------------------------------------------------------------------------
  // Loop state
  // ---------------------------------------------------------------------------
  // Accumulators advance only on a qualified delayed sample; disable restores OFFSET
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_acc <= OFFSET_PH;
      r_freq_acc  <= '0;
      r_sat       <= 1'b0;
    end else if (!i_filter_en) begin
      r_phase_acc <= OFFSET_PH;
      r_freq_acc  <= '0;
      r_sat       <= 1'b0;
    end else if (w_d_v) begin
      r_phase_acc <= w_ph_full[PH_W-1:0];
      r_freq_acc  <= w_freq_next;
      r_sat       <= r_sat | w_clamp;
    end
  end

  assign o_out      = r_phase_acc[PH_W-1:FRAC_BIT];
  assign o_freq_out = r_freq_acc;
  assign o_sat_flag = r_sat;

endmodule
